seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 133 +++++++++++++
 tb/tb_seq_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle ops plus a multi-cycle restoring divider
// Accepts one operation per cycle in IDLE; a nonzero divide holds the block in DIV for DATA_WD cycles.
module seq_alu #(
  parameter int DATA_WD = 8,
  parameter int OUT_WD  = 2 * DATA_WD
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATA_WD-1:0]   A,
  input  logic [DATA_WD-1:0]   B,
  input  logic [3:0]           ALU_FUN,
  output logic [OUT_WD-1:0]    ALU_OUT,
  output logic                 OUT_VALID,
  output logic                 ZERO_FLAG,
  output logic                 DIV_ZERO
);

  localparam int CW = $clog2(DATA_WD);
  localparam logic [OUT_WD-1:0] ONE   = OUT_WD'(1);
  localparam logic [OUT_WD-1:0] TWO   = OUT_WD'(2);
  localparam logic [OUT_WD-1:0] THREE = OUT_WD'(3);
  localparam logic [CW-1:0]     LAST  = CW'(DATA_WD - 1);

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t               r_state;
  logic [DATA_WD-1:0]   r_rem;
  logic [DATA_WD-1:0]   r_quo;
  logic [DATA_WD-1:0]   r_div;
  logic [CW-1:0]        r_cnt;

  logic                 w_accept;
  logic                 w_start_div;
  logic [OUT_WD-1:0]    w_a_ext;
  logic [OUT_WD-1:0]    w_b_ext;
  logic [OUT_WD-1:0]    w_result;
  logic [DATA_WD:0]     w_trial;
  logic [DATA_WD-1:0]   w_rem_nxt;
  logic [DATA_WD-1:0]   w_quo_nxt;
  logic [OUT_WD-1:0]    w_div_res;

  assign IN_READY    = (r_state == S_IDLE);
  assign w_accept    = IN_VALID && IN_READY;
  assign w_start_div = (ALU_FUN == 4'd3) && (B != '0);
  assign w_a_ext     = {{DATA_WD{1'b0}}, A};
  assign w_b_ext     = {{DATA_WD{1'b0}}, B};

  always_comb begin
    w_result = '0;
    case (ALU_FUN)
      4'd0:    w_result = w_a_ext + w_b_ext;
      4'd1:    w_result = w_a_ext - w_b_ext;
      4'd2:    w_result = w_a_ext * w_b_ext;
      4'd3:    w_result = '0;
      4'd4:    w_result = {{DATA_WD{1'b0}}, A & B};
      4'd5:    w_result = {{DATA_WD{1'b0}}, A | B};
      4'd6:    w_result = {{DATA_WD{1'b0}}, ~(A & B)};
      4'd7:    w_result = {{DATA_WD{1'b0}}, ~(A | B)};
      4'd8:    w_result = {{DATA_WD{1'b0}}, A ^ B};
      4'd9:    w_result = {{DATA_WD{1'b0}}, ~(A ^ B)};
      4'd10:   w_result = (A == B) ? ONE : '0;
      4'd11:   w_result = (A > B) ? TWO : '0;
      4'd12:   w_result = (A < B) ? THREE : '0;
      4'd13:   w_result = {{DATA_WD{1'b0}}, A >> 1};
      4'd14:   w_result = w_a_ext << 1;
      default: w_result = '0;
    endcase
  end

  // Restoring step: the remainder is always below the divisor, so the top bit of the trial is the borrow.
  assign w_trial = {r_rem, r_quo[DATA_WD-1]} - {1'b0, r_div};

  always_comb begin
    w_rem_nxt = w_trial[DATA_WD-1:0];
    w_quo_nxt = {r_quo[DATA_WD-2:0], 1'b1};
    if (w_trial[DATA_WD]) begin
      w_rem_nxt = {r_rem[DATA_WD-2:0], r_quo[DATA_WD-1]};
      w_quo_nxt = {r_quo[DATA_WD-2:0], 1'b0};
    end
  end

  assign w_div_res = {w_rem_nxt, w_quo_nxt};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_cnt     <= '0;
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      ZERO_FLAG <= 1'b0;
      DIV_ZERO  <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start_div) begin
              r_rem   <= '0;
              r_quo   <= A;
              r_div   <= B;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end else begin
              ALU_OUT   <= w_result;
              ZERO_FLAG <= (w_result == '0);
              DIV_ZERO  <= (ALU_FUN == 4'd3);
              OUT_VALID <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            ALU_OUT   <= w_div_res;
            ZERO_FLAG <= (w_div_res == '0);
            DIV_ZERO  <= 1'b0;
            OUT_VALID <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu: directed table, reset cases, random ops vs model
module tb_seq_alu;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        ZERO_FLAG;
  logic        DIV_ZERO;

  int n_vec;
  int n_bad;
  logic [15:0] last_out;
  logic        last_zf;
  logic        last_dz;

  seq_alu #(.DATA_WD(8), .OUT_WD(16)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .OUT_VALID(OUT_VALID), .ZERO_FLAG(ZERO_FLAG), .DIV_ZERO(DIV_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;
    logic        zf;
    logic        dz;
  } vec_t;

  localparam int NT = 24;
  vec_t tbl [NT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model written from the opcode table with plain integer arithmetic.
  function automatic logic [15:0] model(input int op, input int a, input int b);
    int r;
    case (op)
      0:  r = a + b;
      1:  r = (a - b) & 32'hFFFF;
      2:  r = a * b;
      3:  r = (b == 0) ? 0 : (((a % b) << 8) | (a / b));
      4:  r = a & b;
      5:  r = a | b;
      6:  r = ~(a & b) & 32'hFF;
      7:  r = ~(a | b) & 32'hFF;
      8:  r = a ^ b;
      9:  r = ~(a ^ b) & 32'hFF;
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 2 : 0;
      12: r = (a < b) ? 3 : 0;
      13: r = a / 2;
      14: r = a * 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  // Called just after a rising edge; returns just after the edge that shows the result.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] eout, input logic ezf, input logic edz);
    IN_VALID = 1'b1; A = a; B = b; ALU_FUN = op;
    chk("in_ready_idle", {31'b0, IN_READY}, 32'd1);
    @(posedge CLK); #1;
    if (op == 4'd3 && b != 8'd0) begin
      for (int i = 1; i <= 8; i++) begin
        chk("div_in_ready_low", {31'b0, IN_READY}, 32'd0);
        chk("div_no_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("div_out_hold", {16'b0, ALU_OUT}, {16'b0, last_out});
        IN_VALID = 1'($urandom); A = 8'($urandom); B = 8'($urandom); ALU_FUN = 4'($urandom);
        @(posedge CLK); #1;
      end
    end
    IN_VALID = 1'b0;
    chk("out_valid", {31'b0, OUT_VALID}, 32'd1);
    chk("alu_out", {16'b0, ALU_OUT}, {16'b0, eout});
    chk("zero_flag", {31'b0, ZERO_FLAG}, {31'b0, ezf});
    chk("div_zero", {31'b0, DIV_ZERO}, {31'b0, edz});
    last_out = eout; last_zf = ezf; last_dz = edz;
  endtask

  task automatic idle_cycle();
    IN_VALID = 1'b0; A = 8'($urandom); B = 8'($urandom); ALU_FUN = 4'($urandom);
    @(posedge CLK); #1;
    chk("idle_no_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("idle_out_hold", {16'b0, ALU_OUT}, {16'b0, last_out});
    chk("idle_zf_hold", {31'b0, ZERO_FLAG}, {31'b0, last_zf});
    chk("idle_dz_hold", {31'b0, DIV_ZERO}, {31'b0, last_dz});
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_alu_out"}, {16'b0, ALU_OUT}, 32'd0);
    chk({nm, "_out_valid"}, {31'b0, OUT_VALID}, 32'd0);
    chk({nm, "_zero_flag"}, {31'b0, ZERO_FLAG}, 32'd0);
    chk({nm, "_div_zero"}, {31'b0, DIV_ZERO}, 32'd0);
    chk({nm, "_in_ready"}, {31'b0, IN_READY}, 32'd1);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    last_out = '0; last_zf = 1'b0; last_dz = 1'b0;
    tbl[0]  = '{4'd0,  8'd200,  8'd100,  16'h012C, 1'b0, 1'b0};
    tbl[1]  = '{4'd1,  8'd5,    8'd7,    16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{4'd2,  8'd255,  8'd255,  16'hFE01, 1'b0, 1'b0};
    tbl[3]  = '{4'd4,  8'hF0,   8'h3C,   16'h0030, 1'b0, 1'b0};
    tbl[4]  = '{4'd3,  8'd200,  8'd7,    16'h041C, 1'b0, 1'b0};
    tbl[5]  = '{4'd3,  8'd9,    8'd0,    16'h0000, 1'b1, 1'b1};
    tbl[6]  = '{4'd0,  8'd1,    8'd1,    16'h0002, 1'b0, 1'b0};
    tbl[7]  = '{4'd5,  8'hA0,   8'h05,   16'h00A5, 1'b0, 1'b0};
    tbl[8]  = '{4'd6,  8'hF0,   8'h3C,   16'h00CF, 1'b0, 1'b0};
    tbl[9]  = '{4'd7,  8'hF0,   8'h0F,   16'h0000, 1'b1, 1'b0};
    tbl[10] = '{4'd8,  8'hFF,   8'h0F,   16'h00F0, 1'b0, 1'b0};
    tbl[11] = '{4'd9,  8'hAA,   8'h55,   16'h0000, 1'b1, 1'b0};
    tbl[12] = '{4'd10, 8'd5,    8'd5,    16'h0001, 1'b0, 1'b0};
    tbl[13] = '{4'd10, 8'd5,    8'd6,    16'h0000, 1'b1, 1'b0};
    tbl[14] = '{4'd11, 8'd9,    8'd3,    16'h0002, 1'b0, 1'b0};
    tbl[15] = '{4'd11, 8'd3,    8'd9,    16'h0000, 1'b1, 1'b0};
    tbl[16] = '{4'd12, 8'd3,    8'd9,    16'h0003, 1'b0, 1'b0};
    tbl[17] = '{4'd13, 8'h81,   8'h00,   16'h0040, 1'b0, 1'b0};
    tbl[18] = '{4'd14, 8'h81,   8'h00,   16'h0102, 1'b0, 1'b0};
    tbl[19] = '{4'd15, 8'd7,    8'd7,    16'h0000, 1'b1, 1'b0};
    tbl[20] = '{4'd3,  8'd255,  8'd1,    16'h00FF, 1'b0, 1'b0};
    tbl[21] = '{4'd3,  8'd5,    8'd200,  16'h0500, 1'b0, 1'b0};
    tbl[22] = '{4'd3,  8'd0,    8'd3,    16'h0000, 1'b1, 1'b0};
    tbl[23] = '{4'd3,  8'd9,    8'd0,    16'h0000, 1'b1, 1'b1};

    RST = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    #1;
    chk_reset_outputs("por");
    #1 RST = 1'b1;
    @(posedge CLK); #1;

    // Directed table applied back-to-back; MUL then AND land on consecutive cycles.
    for (int i = 0; i < NT; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].zf, tbl[i].dz);
    idle_cycle();

    // Asynchronous reset mid-cycle with flags set from the divide-by-zero.
    #2 RST = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #1 RST = 1'b1;
    last_out = '0; last_zf = 1'b0; last_dz = 1'b0;
    @(posedge CLK); #1;
    run_op(4'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0);

    // Reset during a divide aborts it with no result pulse.
    IN_VALID = 1'b1; A = 8'd200; B = 8'd7; ALU_FUN = 4'd3;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("abort_in_div", {31'b0, IN_READY}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
    end
    #2 RST = 1'b0;
    #1;
    chk_reset_outputs("div_abort");
    #1 RST = 1'b1;
    last_out = '0; last_zf = 1'b0; last_dz = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("abort_no_valid", {31'b0, OUT_VALID}, 32'd0);
      chk("abort_ready", {31'b0, IN_READY}, 32'd1);
    end
    run_op(4'd0, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0);

    // Randomized operations checked against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] e;
      op = 4'($urandom);
      if ($urandom_range(0, 3) == 0) op = 4'd3;
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b = 8'd0;
        1: b = a;
        default: ;
      endcase
      e = model(int'(op), int'(a), int'(b));
      run_op(op, a, b, e, (e == 16'd0), (op == 4'd3 && b == 8'd0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
